// File: rtl/fpga2_selfcheck.sv
// Hex digit to 7-segment decoder with an independently predicted Berger check symbol.
// One cycle latency; the two-rail checker output is combinational from the registered outputs.
module fpga2_selfcheck (
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic g0,
  output logic g1,
  output logic g2,
  output logic g3,
  output logic g4,
  output logic g5,
  output logic g6,
  output logic e,
  output logic f,
  output logic g,
  output logic x,
  output logic y
);

  logic [3:0] w_digit;
  logic [6:0] w_seg;    // bit 6 = g0 (segment a) ... bit 0 = g6 (segment g)
  logic [2:0] w_chk;
  logic [2:0] w_zeros;
  logic [6:0] r_seg;
  logic [2:0] r_chk;

  assign w_digit = {a, b, c, d};

  always_comb begin
    w_seg = 7'b0000000;
    case (w_digit)
      4'h0: w_seg = 7'b1111110;
      4'h1: w_seg = 7'b0110000;
      4'h2: w_seg = 7'b1101101;
      4'h3: w_seg = 7'b1111001;
      4'h4: w_seg = 7'b0110011;
      4'h5: w_seg = 7'b1011011;
      4'h6: w_seg = 7'b1011111;
      4'h7: w_seg = 7'b1110000;
      4'h8: w_seg = 7'b1111111;
      4'h9: w_seg = 7'b1111011;
      4'hA: w_seg = 7'b1110111;
      4'hB: w_seg = 7'b0011111;
      4'hC: w_seg = 7'b1001110;
      4'hD: w_seg = 7'b0111101;
      4'hE: w_seg = 7'b1001111;
      4'hF: w_seg = 7'b1000111;
      default: w_seg = 7'b0000000;
    endcase
  end

  // Check symbol comes straight from the digit so a segment-logic fault cannot track into it.
  always_comb begin
    w_chk = 3'd0;
    case (w_digit)
      4'h0: w_chk = 3'd1;
      4'h1: w_chk = 3'd5;
      4'h2: w_chk = 3'd2;
      4'h3: w_chk = 3'd2;
      4'h4: w_chk = 3'd3;
      4'h5: w_chk = 3'd2;
      4'h6: w_chk = 3'd1;
      4'h7: w_chk = 3'd4;
      4'h8: w_chk = 3'd0;
      4'h9: w_chk = 3'd1;
      4'hA: w_chk = 3'd1;
      4'hB: w_chk = 3'd2;
      4'hC: w_chk = 3'd3;
      4'hD: w_chk = 3'd2;
      4'hE: w_chk = 3'd2;
      4'hF: w_chk = 3'd3;
      default: w_chk = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= 7'b0000000;
      r_chk <= 3'b111;
    end else begin
      r_seg <= w_seg;
      r_chk <= w_chk;
    end
  end

  always_comb begin
    w_zeros = 3'd0;
    for (int i = 0; i < 7; i++) begin
      w_zeros = w_zeros + {2'b00, ~r_seg[i]};
    end
  end

  assign {g0, g1, g2, g3, g4, g5, g6} = r_seg;
  assign {e, f, g} = r_chk;

  // Rail 0 is held high so the checker only ever emits 10 (ok) or 11 (error).
  assign x = 1'b1;
  assign y = (w_zeros != r_chk);

endmodule

// File: tb/tb_fpga2_selfcheck.sv
// Directed bench for fpga2_selfcheck: expected outputs are queued at drive time and popped one cycle later.
module tb_fpga2_selfcheck;

  logic clk = 1'b0;
  logic rst, a, b, c, d;
  logic g0, g1, g2, g3, g4, g5, g6, e, f, g, x, y;

  typedef struct packed {
    logic [6:0] seg;
    logic [2:0] chk;
    logic [1:0] xy;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0;
  int n_bad = 0;

  // Segment rows and zero counts, digit 0..F, g0 first.
  logic [6:0] SEG [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [2:0] BRG [16] = '{3'd1, 3'd5, 3'd2, 3'd2, 3'd3, 3'd2, 3'd1, 3'd4,
                           3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd2, 3'd2, 3'd3};

  fpga2_selfcheck dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c), .d(d),
    .g0(g0), .g1(g1), .g2(g2), .g3(g3), .g4(g4), .g5(g5), .g6(g6),
    .e(e), .f(f), .g(g), .x(x), .y(y)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, expv);
    end
  endtask

  task automatic apply(input logic [3:0] dig, input logic rst_v, input string tag);
    exp_t ex;
    {a, b, c, d} = dig;
    rst = rst_v;
    if (rst_v) ex = '{seg: 7'b0000000, chk: 3'b111, xy: 2'b10};
    else       ex = '{seg: SEG[dig], chk: BRG[dig], xy: 2'b10};
    sb.push_back(ex);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      n_vec++;
      n_bad++;
      $error("FAIL %s: observed empty scoreboard, expected entry", tag);
    end else begin
      ex = sb.pop_front();
      check({tag, ".seg"}, {1'b0, g0, g1, g2, g3, g4, g5, g6}, {1'b0, ex.seg});
      check({tag, ".efg"}, {5'b0, e, f, g}, {5'b0, ex.chk});
      check({tag, ".xy"},  {6'b0, x, y},    {6'b0, ex.xy});
    end
  endtask

  initial begin
    logic [3:0] seq [8];
    seq = '{4'b0001, 4'b1000, 4'b1001, 4'b0101, 4'b1011, 4'b0111, 4'b0110, 4'b1111};
    rst = 1'b1;
    {a, b, c, d} = 4'b1111;
    @(negedge clk);

    apply(4'b1111, 1'b1, "reset0");
    apply(4'b1111, 1'b1, "reset1");

    for (int i = 0; i < 8; i++) apply(seq[i], 1'b0, $sformatf("seq%0d", i));

    for (int i = 0; i < 16; i++) apply(i[3:0], 1'b0, $sformatf("exh%0h", i));

    apply(4'h8, 1'b0, "show8");
    force dut.r_seg = 7'b1110111;
    #1;
    check("force_g3.xy", {6'b0, x, y}, 8'b0000_0011);
    release dut.r_seg;
    apply(4'h8, 1'b0, "release_g3");

    apply(4'h0, 1'b0, "show0");
    force dut.r_chk = 3'b000;
    #1;
    check("force_efg.xy", {6'b0, x, y}, 8'b0000_0011);
    release dut.r_chk;
    apply(4'h0, 1'b0, "release_efg");

    apply(4'h7, 1'b0, "show7");
    apply(4'h7, 1'b1, "midreset");
    apply(4'b0010, 1'b0, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
